// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I pipeline types and constants.
// Fetch-related items: datapath width, canonical NOP, fetch reset PC
// and the {instr, pc} entry carried from fetch to decode.
package rv32i_pkg;

    localparam int DPW = 32;

    // addi x0, x0, 0
    localparam logic [DPW-1:0] INSTR_NOP      = 32'h0000_0013;
    localparam logic [DPW-1:0] FETCH_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [DPW-1:0] instr;
        logic [DPW-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small circular FIFO of fetch_entry_t.
// Ports:
//   clk, rst     clock / async active-high reset
//   push, din    write an entry (ignored when full unless popping too)
//   pop, dout    dout is the head, valid whenever count != 0
//   flush        empties the FIFO; wins over push/pop
//   count        current occupancy
// Push and pop in the same cycle are legal at any occupancy.
module fetch_fifo
    import rv32i_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  fetch_entry_t  din,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  dout,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic            do_push, do_pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (int'(p) == DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    assign do_pop  = !flush && pop && (count != '0);
    // A simultaneous pop frees the slot, so a push at full is still accepted.
    assign do_push = !flush && push && ((int'(count) < DEPTH) || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= inc(wr_ptr);
            if (do_pop)  rd_ptr <= inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction fetch plus IF/ID register.
// Ports:
//   clk, rst                      clock / async active-high reset
//   imem_req/addr/gnt             request channel (ungranted requests may be retracted)
//   imem_rvalid/rdata             in-order response channel
//   stallD                        decode cannot accept; hold IF/ID
//   redirect_valid/redirect_pc    EX-stage redirect, overrides stall
//   instrD, pcD, pcplus4D, validD IF/ID register outputs
// Requests are credit-limited so that every outstanding response always has
// a free response-buffer slot. After a redirect, responses still in flight
// are counted off by 'discard' and dropped.
module fetch_stage
    import rv32i_pkg::*;
#(
    parameter logic [DPW-1:0] RESET_PC   = FETCH_RESET_PC,
    parameter int             FIFO_DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst,
    output logic           imem_req,
    output logic [DPW-1:0] imem_addr,
    input  logic           imem_gnt,
    input  logic           imem_rvalid,
    input  logic [DPW-1:0] imem_rdata,
    input  logic           stallD,
    input  logic           redirect_valid,
    input  logic [DPW-1:0] redirect_pc,
    output logic [DPW-1:0] instrD,
    output logic [DPW-1:0] pcD,
    output logic [DPW-1:0] pcplus4D,
    output logic           validD
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [DPW-1:0] pcF;
    logic [CW-1:0]  outstanding, discard;
    logic [CW-1:0]  rsp_cnt, pcq_cnt;
    fetch_entry_t   rsp_dout, pcq_dout, pcq_din, live_entry;
    logic           grant, rsp_any, live;
    logic           rsp_push, rsp_pop;

    assign imem_addr = pcF;
    assign imem_req  = !rst && !redirect_valid
                       && ((int'(outstanding) + int'(rsp_cnt)) < FIFO_DEPTH);
    assign grant     = imem_req && imem_gnt;

    // Any response retires one outstanding request; it is live only when it
    // belongs to the current path and is not killed by a redirect this cycle.
    assign rsp_any   = imem_rvalid && (outstanding != '0);
    assign live      = rsp_any && (discard == '0) && !redirect_valid
                       && (pcq_cnt != '0);

    always_comb begin
        pcq_din       = '0;
        pcq_din.instr = INSTR_NOP;
        pcq_din.pc    = pcF;
        live_entry       = pcq_dout;
        live_entry.instr = imem_rdata;
    end

    // Buffer a live word unless it can go straight into IF/ID this cycle.
    assign rsp_pop  = !redirect_valid && !stallD && (rsp_cnt != '0);
    assign rsp_push = live && (stallD || (rsp_cnt != '0));

    fetch_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_pcq (
        .clk   (clk),
        .rst   (rst),
        .push  (grant),
        .din   (pcq_din),
        .pop   (live),
        .flush (redirect_valid),
        .dout  (pcq_dout),
        .count (pcq_cnt)
    );

    fetch_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_rspq (
        .clk   (clk),
        .rst   (rst),
        .push  (rsp_push),
        .din   (live_entry),
        .pop   (rsp_pop),
        .flush (redirect_valid),
        .dout  (rsp_dout),
        .count (rsp_cnt)
    );

    // PC and credit counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcF         <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            if (redirect_valid)
                pcF <= {redirect_pc[DPW-1:2], 2'b00};
            else if (grant)
                pcF <= pcF + 32'd4;

            case ({grant, rsp_any})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase

            // No grant can happen in a redirect cycle, so everything still
            // outstanding after this cycle's response is wrong-path.
            if (redirect_valid)
                discard <= outstanding - CW'(rsp_any);
            else if (rsp_any && (discard != '0))
                discard <= discard - CW'(1);
        end
    end

    // IF/ID register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            validD   <= 1'b0;
            instrD   <= INSTR_NOP;
            pcD      <= '0;
            pcplus4D <= '0;
        end else if (redirect_valid) begin
            validD <= 1'b0;
            instrD <= INSTR_NOP;
        end else if (!stallD) begin
            if (rsp_cnt != '0) begin
                validD   <= 1'b1;
                instrD   <= rsp_dout.instr;
                pcD      <= rsp_dout.pc;
                pcplus4D <= rsp_dout.pc + 32'd4;
            end else if (live) begin
                validD   <= 1'b1;
                instrD   <= live_entry.instr;
                pcD      <= live_entry.pc;
                pcplus4D <= live_entry.pc + 32'd4;
            end else begin
                validD <= 1'b0;
                instrD <= INSTR_NOP;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed + randomized checks of fetch_stage against a
// program-order reference (expected PC stream, restarted on each redirect)
// and an in-order memory model that answers granted addresses.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        stallD, redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] instrD, pcD, pcplus4D;
    logic        validD;

    int          checks = 0;
    int          failures = 0;

    logic [31:0] pend[$];          // granted, not yet answered addresses
    logic [31:0] exp_pc;           // next PC decode must see
    logic [31:0] prev_instr, prev_pc, prev_pc4;
    logic        prev_valid;
    int          delivered = 0;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .stallD         (stallD),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instrD         (instrD),
        .pcD            (pcD),
        .pcplus4D       (pcplus4D),
        .validD         (validD)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ref_reset();
        pend.delete();
        exp_pc     = 32'h0;
        prev_valid = 1'b0;
        prev_instr = NOP;
        prev_pc    = 32'h0;
        prev_pc4   = 32'h0;
    endtask

    // One clock: drive inputs, let the memory model see the grant, then
    // score the IF/ID register at the following negedge.
    task automatic tick(input bit g, input bit rv, input bit st, input bit rd,
                        input logic [31:0] rpc);
        imem_gnt       = g;
        stallD         = st;
        redirect_valid = rd;
        redirect_pc    = rpc;
        imem_rvalid    = rv && (pend.size() != 0);
        imem_rdata     = 32'h0;
        if (imem_rvalid) imem_rdata = memf(pend[0]);
        #1;
        if (imem_rvalid) void'(pend.pop_front());
        if (imem_req && imem_gnt) pend.push_back(imem_addr);
        @(posedge clk);
        @(negedge clk);
        if (rd) begin
            chk("redir_valid", {31'b0, validD}, 32'h0);
            chk("redir_nop", instrD, NOP);
            exp_pc = {rpc[31:2], 2'b00};
        end else if (st) begin
            chk("stall_valid", {31'b0, validD}, {31'b0, prev_valid});
            chk("stall_instr", instrD, prev_instr);
            chk("stall_pc", pcD, prev_pc);
            chk("stall_pc4", pcplus4D, prev_pc4);
        end else if (validD) begin
            chk("seq_pc", pcD, exp_pc);
            chk("seq_instr", instrD, memf(exp_pc));
            chk("seq_pc4", pcplus4D, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            delivered++;
        end else begin
            chk("bubble_nop", instrD, NOP);
        end
        prev_valid = validD;
        prev_instr = instrD;
        prev_pc    = pcD;
        prev_pc4   = pcplus4D;
    endtask

    // Let every outstanding response return and the buffer empty.
    task automatic drain();
        for (int i = 0; i < 20 && pend.size() != 0; i++) tick(0, 1, 0, 0, 0);
        chk("drain_done", pend.size(), 0);
        repeat (3) tick(0, 1, 0, 0, 0);
    endtask

    task automatic wait_valid(input string tag, input logic [31:0] want);
        int n;
        n = 0;
        while (!validD && n < 20) begin
            tick(1, 1, 0, 0, 0);
            n++;
        end
        chk({tag, "_seen"}, {31'b0, validD}, 32'h1);
        chk({tag, "_pc"}, pcD, want);
    endtask

    initial begin
        logic [31:0] a0;
        int d0;
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
        stallD = 0; redirect_valid = 0; redirect_pc = 0;
        ref_reset();

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_valid", {31'b0, validD}, 32'h0);
        chk("rst_instr", instrD, NOP);
        chk("rst_pcD", pcD, 32'h0);
        chk("rst_pc4", pcplus4D, 32'h0);
        rst = 1'b0;
        #1;
        chk("rel_addr", imem_addr, 32'h0);
        chk("rel_req", {31'b0, imem_req}, 32'h1);

        // Zero-wait stream: gnt N, rvalid N+1, validD N+2, then 1/cycle
        tick(1, 1, 0, 0, 0);
        chk("lat_n1_valid", {31'b0, validD}, 32'h0);
        tick(1, 1, 0, 0, 0);
        chk("stream_pc0", pcD, 32'h0);
        chk("stream_v0", {31'b0, validD}, 32'h1);
        tick(1, 1, 0, 0, 0);
        chk("stream_pc4", pcD, 32'h4);
        tick(1, 1, 0, 0, 0);
        chk("stream_pc8", pcD, 32'h8);
        chk("stream_pc8_p4", pcplus4D, 32'hC);

        // Stall 3 cycles while responses arrive: buffer fills, req drops
        repeat (3) tick(1, 1, 1, 0, 0);
        chk("stall_full_req", {31'b0, imem_req}, 32'h0);
        repeat (8) tick(1, 1, 0, 0, 0);

        // Redirect with 2 outstanding
        drain();
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        chk("two_outstanding", pend.size(), 2);
        tick(0, 0, 0, 1, 32'h100);
        wait_valid("redir100", 32'h100);
        repeat (4) tick(1, 1, 0, 0, 0);

        // Grant withheld 4 cycles
        drain();
        a0 = imem_addr;
        for (int i = 0; i < 4; i++) begin
            tick(0, 1, 0, 0, 0);
            chk("nognt_req", {31'b0, imem_req}, 32'h1);
            chk("nognt_addr", imem_addr, a0);
            chk("nognt_valid", {31'b0, validD}, 32'h0);
        end

        // Redirect coincident with stall and a live response (misaligned target)
        tick(1, 0, 0, 0, 0);
        tick(1, 1, 0, 0, 0);
        tick(0, 1, 1, 1, 32'h203);
        chk("coinc_valid", {31'b0, validD}, 32'h0);
        wait_valid("coinc200", 32'h200);

        // Reset mid-fetch
        tick(1, 0, 0, 0, 0);
        imem_gnt = 0; imem_rvalid = 0;
        rst = 1'b1;
        #1;
        chk("midrst_req_async", {31'b0, imem_req}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("midrst_req", {31'b0, imem_req}, 32'h0);
        chk("midrst_valid", {31'b0, validD}, 32'h0);
        chk("midrst_instr", instrD, NOP);
        ref_reset();
        rst = 1'b0;
        #1;
        chk("midrst_addr", imem_addr, 32'h0);
        wait_valid("midrst_first", 32'h0);

        // Randomized traffic
        d0 = delivered;
        for (int i = 0; i < 3000; i++)
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 49) == 0, $urandom);
        chk("rand_progress", (delivered - d0 > 300) ? 32'h1 : 32'h0, 32'h1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
